// File: rtl/lsu_axi_gen2.sv
// Load/store unit bridging EXU requests to an AXI4-Lite data port (RV32/RV64).
// Loads use AR/R with alignment and extension; stores use AW/W/B with lane strobes.
module lsu_axi_gen2 #(
    parameter int DATA_LEN     = 64,
    parameter int DATA_BIT_NUM = DATA_LEN / 8,
    parameter int ADDR_LEN     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_LEN-1:0]     req_addr,
    input  logic [DATA_LEN-1:0]     req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_LEN-1:0]     resp_rdata,
    output logic                    resp_wen,
    output logic [1:0]              resp_err,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_LEN-1:0]     awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_LEN-1:0]     wdata,
    output logic [DATA_BIT_NUM-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_LEN-1:0]     araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_LEN-1:0]     rdata,
    input  logic [1:0]              rresp
);
    localparam int OFFW = $clog2(DATA_BIT_NUM);

    typedef enum logic [2:0] {IDLE, LD_AR, LD_R, ST_AWW, ST_B, RESP} state_e;

    state_e                state_q, state_d;
    logic                  st_q, st_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [DATA_LEN-1:0]   wdat_q, wdat_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_LEN-1:0]   rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;
    logic                  wen_q, wen_d;

    logic                  misalign;
    logic [OFFW-1:0]       offset;
    logic [DATA_LEN-1:0]   ld_shift, ld_top, ld_ext;
    logic [6:0]            sh_amt;
    logic [DATA_BIT_NUM-1:0] lane_mask;

    assign offset = addr_q[OFFW-1:0];

    always_comb begin
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            default: misalign = (|req_addr[2:0]) || (DATA_LEN == 32);
        endcase
    end

    // Extension by parking the field at the MSB and shifting back down.
    always_comb begin
        ld_shift = rdata >> {offset, 3'b000};
        case (size_q)
            2'd0:    sh_amt = 7'(DATA_LEN - 8);
            2'd1:    sh_amt = 7'(DATA_LEN - 16);
            2'd2:    sh_amt = 7'(DATA_LEN - 32);
            default: sh_amt = '0;
        endcase
        ld_top = ld_shift << sh_amt;
        if (uns_q) ld_ext = ld_top >> sh_amt;
        else       ld_ext = $signed(ld_top) >>> sh_amt;
    end

    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < DATA_BIT_NUM; i++)
            lane_mask[i] = (i < (32'd1 << size_q));
    end

    assign req_ready  = (state_q == IDLE);
    assign arvalid    = (state_q == LD_AR);
    assign rready     = (state_q == LD_R);
    assign awvalid    = (state_q == ST_AWW) && !aw_done_q;
    assign wvalid     = (state_q == ST_AWW) && !w_done_q;
    assign bready     = (state_q == ST_B);
    assign resp_valid = (state_q == RESP);
    assign resp_wen   = wen_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign araddr     = {addr_q[ADDR_LEN-1:OFFW], {OFFW{1'b0}}};
    assign awaddr     = araddr;
    assign wdata      = wdat_q << {offset, 3'b000};
    assign wstrb      = lane_mask << offset;

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wen_d     = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                st_d      = req_is_store;
                size_d    = req_size;
                uns_d     = req_unsigned;
                addr_d    = req_addr;
                wdat_d    = req_wdata;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                rdata_d   = '0;
                err_d     = 2'b00;
                if (misalign) begin
                    err_d   = 2'b01;
                    state_d = RESP;
                end else begin
                    state_d = req_is_store ? ST_AWW : LD_AR;
                end
            end
            LD_AR: if (arready) state_d = LD_R;
            LD_R: if (rvalid) begin
                if (rresp != 2'b00) begin
                    err_d   = 2'b10;
                    rdata_d = '0;
                end else begin
                    rdata_d = ld_ext;
                    wen_d   = 1'b1;
                end
                state_d = RESP;
            end
            ST_AWW: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = ST_B;
            end
            ST_B: if (bvalid) begin
                err_d   = (bresp != 2'b00) ? 2'b10 : 2'b00;
                state_d = RESP;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            st_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= '0;
            wen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wen_q     <= wen_d;
        end
    end
endmodule

// File: tb/tb_lsu_axi_gen2.sv
// Directed bench for lsu_axi_gen2 (RV64) with a small AXI-Lite slave model
// and a response scoreboard.
module tb_lsu_axi_gen2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_wen;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    lsu_axi_gen2 #(.DATA_LEN(64), .ADDR_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_wen(resp_wen), .resp_err(resp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    // Slave knobs
    logic [63:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = '0, slv_bresp = '0;
    int          aw_delay = 0;
    bit          r_hold = 1'b0;
    int          aw_cnt;
    logic        aw_seen, w_seen;
    logic        aw_f, w_f;

    assign arready = 1'b1;
    assign wready  = 1'b1;
    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign aw_f    = aw_seen | (awvalid & awready);
    assign w_f     = w_seen | (wvalid & wready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0; rdata <= '0; rresp <= '0;
            bvalid <= 1'b0; bresp <= '0;
            aw_seen <= 1'b0; w_seen <= 1'b0; aw_cnt <= 0;
        end else begin
            if (arvalid && arready && !r_hold) begin
                rvalid <= 1'b1; rdata <= slv_rdata; rresp <= slv_rresp;
            end else if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) aw_cnt <= 0;
            else if (awvalid)       aw_cnt <= aw_cnt + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_f && w_f) begin
                bvalid <= 1'b1; bresp <= slv_bresp;
                aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                aw_seen <= aw_f; w_seen <= w_f;
            end
        end
    end

    // Bus monitors, sampled mid-cycle
    int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0, wen_cnt = 0, b_cnt = 0;
    logic [31:0] mon_araddr = '0, mon_awaddr = '0;
    logic [63:0] mon_wdata = '0;
    logic [7:0]  mon_wstrb = '0;
    always @(negedge clk) begin
        if (arvalid) begin ar_cyc <= ar_cyc + 1; mon_araddr <= araddr; end
        if (awvalid) begin aw_cyc <= aw_cyc + 1; mon_awaddr <= awaddr; end
        if (wvalid)  begin w_cyc <= w_cyc + 1; mon_wdata <= wdata; mon_wstrb <= wstrb; end
        if (resp_wen) wen_cnt <= wen_cnt + 1;
        if (bvalid && bready) b_cnt <= b_cnt + 1;
    end

    typedef struct packed { logic [63:0] rd; logic [1:0] err; logic wen; } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int ar0, aw0, w0, wen0, b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        ar0 = ar_cyc; aw0 = aw_cyc; w0 = w_cyc; wen0 = wen_cnt; b0 = b_cnt;
    endtask

    task automatic run(input string nm, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                       input logic [1:0] exp_err, input bit exp_wen, input int exp_lat,
                       input int hold);
        int   lat;
        exp_t e;
        @(negedge clk);
        snap();
        req_is_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        sb.push_back('{rd: exp_rd, err: exp_err, wen: exp_wen});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
        chk({nm, "_resp_valid"}, 64'(resp_valid), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        e = sb.pop_front();
        chk({nm, "_rdata"}, resp_rdata, e.rd);
        chk({nm, "_err"}, 64'(resp_err), 64'(e.err));
        chk({nm, "_wen_first"}, 64'(resp_wen), 64'(e.wen));
        for (int i = 0; i < hold; i++) begin
            req_is_store = 1'b1; req_size = 2'd0; req_addr = 32'h8000_0100; req_valid = 1'b1;
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(resp_valid), 64'd1);
            chk({nm, "_hold_rdata"}, resp_rdata, e.rd);
            chk({nm, "_hold_err"}, 64'(resp_err), 64'(e.err));
            chk({nm, "_hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_idle_req_ready"}, 64'(req_ready), 64'd1);
        chk({nm, "_idle_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({nm, "_wen_pulses"}, 64'(wen_cnt - wen0), 64'(exp_wen));
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // lb / lbu sign handling
        slv_rdata = 64'h0000_0000_8000_0000;
        run("lb", 1'b0, 2'd0, 1'b0, 32'h8000_0003, '0, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 1'b1, 3, 0);
        chk("lb_araddr", 64'(mon_araddr), 64'h8000_0000);
        chk("lb_ar_cycles", 64'(ar_cyc - ar0), 64'd1);
        run("lbu", 1'b0, 2'd0, 1'b1, 32'h8000_0003, '0, 64'h0000_0000_0000_0080, 2'b00, 1'b1, 3, 0);

        // sh with delayed awready
        aw_delay = 3;
        run("sh", 1'b1, 2'd1, 1'b0, 32'h8000_0006, 64'h1234, 64'd0, 2'b00, 1'b0, 6, 0);
        chk("sh_wstrb", 64'(mon_wstrb), 64'hC0);
        chk("sh_wdata", mon_wdata, 64'h1234_0000_0000_0000);
        chk("sh_awaddr", 64'(mon_awaddr), 64'h8000_0000);
        chk("sh_w_cycles", 64'(w_cyc - w0), 64'd1);
        chk("sh_aw_cycles", 64'(aw_cyc - aw0), 64'd4);
        chk("sh_b_count", 64'(b_cnt - b0), 64'd1);
        aw_delay = 0;

        // Misaligned word
        run("lw_mis", 1'b0, 2'd2, 1'b0, 32'h8000_0002, '0, 64'd0, 2'b01, 1'b0, 1, 0);
        chk("mis_ar_cycles", 64'(ar_cyc - ar0), 64'd0);
        chk("mis_aw_cycles", 64'(aw_cyc - aw0), 64'd0);

        // Bus errors
        slv_rdata = 64'hDEAD_BEEF_CAFE_F00D; slv_rresp = 2'b10;
        run("ld_err", 1'b0, 2'd3, 1'b0, 32'h8000_0008, '0, 64'd0, 2'b10, 1'b0, 3, 0);
        chk("ld_err_araddr", 64'(mon_araddr), 64'h8000_0008);
        slv_rresp = 2'b00; slv_bresp = 2'b11;
        run("sd_err", 1'b1, 2'd3, 1'b0, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b10, 1'b0, 3, 0);
        chk("sd_wstrb", 64'(mon_wstrb), 64'hFF);
        chk("sd_wdata", mon_wdata, 64'h0123_4567_89AB_CDEF);
        slv_bresp = 2'b00;

        // Back-pressured response with ignored request during RESP
        slv_rdata = 64'h1111_2222_8765_4321;
        run("lw_hold", 1'b0, 2'd2, 1'b0, 32'h8000_0000, '0, 64'hFFFF_FFFF_8765_4321, 2'b00, 1'b1, 3, 4);
        repeat (3) @(negedge clk);
        chk("hold_ar_cycles", 64'(ar_cyc - ar0), 64'd1);
        chk("hold_aw_cycles", 64'(aw_cyc - aw0), 64'd0);

        // Reset while waiting on R
        r_hold = 1'b1;
        @(negedge clk);
        req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000_0000;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_rready_before", 64'(rready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_arvalid", 64'(arvalid), 64'd0);
        chk("abort_rready", 64'(rready), 64'd0);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; r_hold = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_no_resp", 64'(resp_valid), 64'd0);
        slv_rdata = 64'h7FFF_FFFF_0000_0000;
        run("lw_after", 1'b0, 2'd2, 1'b0, 32'h8000_0004, '0, 64'h0000_0000_7FFF_FFFF, 2'b00, 1'b1, 3, 0);
        chk("lw_after_araddr", 64'(mon_araddr), 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
